// File: rtl/grf_wb_arb.sv
// Arbitrates the GRF write port between the W-stage pipe and a 2-entry MDU queue, with age-based stall.
// Optional macro GRF_WB_TRACE_EN prints one trace line per committed register write.
module grf_wb_arb #(
  parameter int unsigned MAX_AGE = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_a3,
  input  logic [31:0] pipe_wd,
  input  logic [31:0] pipe_pc,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_a3,
  input  logic [31:0] mdu_wd,
  input  logic [31:0] mdu_pc,
  output logic        mdu_ready,
  output logic        stall,
  input  logic [4:0]  rd_a,
  output logic        pend_hit,
  output logic        grf_we,
  output logic [4:0]  grf_a3,
  output logic [31:0] grf_wd,
  output logic [31:0] grf_pc
);

  localparam int unsigned AW = (MAX_AGE > 1) ? $clog2(MAX_AGE) : 1;

  typedef struct packed {
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pc;
  } wb_req_t;

  wb_req_t       mem [2];
  logic          rd_ptr, wr_ptr;
  logic [1:0]    count;
  logic [AW-1:0] age;

  logic    empty, full, push, pop, pipe_win, sel_we;
  wb_req_t head, sel_req;

  assign empty     = (count == 2'd0);
  assign full      = (count == 2'd2);
  assign mdu_ready = !full && !reset;
  assign push      = mdu_valid && mdu_ready;
  assign stall     = !reset && !empty && (age == AW'(MAX_AGE - 1));
  assign pipe_win  = !stall && pipe_we && (pipe_a3 != 5'd0);
  assign pop       = !reset && !empty && !pipe_win;
  assign head      = mem[rd_ptr];

  // A popped head with a3=0 is consumed but never written.
  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    sel_we  = 1'b0;
    sel_req = head;
    if (pipe_win) begin
      sel_we  = 1'b1;
      sel_req = '{a3: pipe_a3, wd: pipe_wd, pc: pipe_pc};
    end else if (pop) begin
      sel_we  = (head.a3 != 5'd0);
    end
  end

  always_comb begin
    pend_hit = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if ((full || (count == 2'd1 && rd_ptr == 1'(i))) && mem[i].a3 == rd_a)
        pend_hit = 1'b1;
    end
    pend_hit = pend_hit && (rd_a != 5'd0) && !reset;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
      age    <= '0;
    end else begin
      if (push) wr_ptr <= !wr_ptr;
      if (pop)  rd_ptr <= !rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (pop || empty)
        age <= '0;
      else if (age != AW'(MAX_AGE - 1))
        age <= age + AW'(1);
    end
  end

  // NOTE: queue storage has no reset; entries are only observed through count/pointers, which are reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{a3: mdu_a3, wd: mdu_wd, pc: mdu_pc};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grf_we <= 1'b0;
      grf_a3 <= 5'd0;
      grf_wd <= 32'd0;
      grf_pc <= 32'd0;
    end else begin
      grf_we <= sel_we;
      if (sel_we) begin
        grf_a3 <= sel_req.a3;
        grf_wd <= sel_req.wd;
        grf_pc <= sel_req.pc;
      end
    end
  end

`ifdef GRF_WB_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset && sel_we)
      $display("@%h: $%0d <= %h", sel_req.pc, sel_req.a3, sel_req.wd);
  end
`endif

endmodule

// File: tb/tb_grf_wb_arb.sv
// Directed, table-driven bench for grf_wb_arb (MAX_AGE = 8): per-cycle vectors plus an age/stall sequence.
module tb_grf_wb_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_we;
  logic [4:0]  pipe_a3;
  logic [31:0] pipe_wd, pipe_pc;
  logic        mdu_valid;
  logic [4:0]  mdu_a3;
  logic [31:0] mdu_wd, mdu_pc;
  logic        mdu_ready, stall, pend_hit, grf_we;
  logic [4:0]  rd_a, grf_a3;
  logic [31:0] grf_wd, grf_pc;

  int total = 0;
  int bad   = 0;

  grf_wb_arb #(.MAX_AGE(8)) dut (
    .clk(clk), .reset(reset),
    .pipe_we(pipe_we), .pipe_a3(pipe_a3), .pipe_wd(pipe_wd), .pipe_pc(pipe_pc),
    .mdu_valid(mdu_valid), .mdu_a3(mdu_a3), .mdu_wd(mdu_wd), .mdu_pc(mdu_pc),
    .mdu_ready(mdu_ready), .stall(stall), .rd_a(rd_a), .pend_hit(pend_hit),
    .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc(grf_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        pwe;
    logic [4:0]  pa3;
    logic [31:0] pwd, ppc;
    logic        mv;
    logic [4:0]  ma3;
    logic [31:0] mwd, mpc;
    logic [4:0]  rda;
    logic        e_rdy, e_stl, e_hit, e_we;
    logic [4:0]  e_a3;
    logic [31:0] e_wd, e_pc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(
    input logic rst, input logic pwe, input logic [4:0] pa3, input logic [31:0] pwd, input logic [31:0] ppc,
    input logic mv, input logic [4:0] ma3, input logic [31:0] mwd, input logic [31:0] mpc, input logic [4:0] rda,
    input logic e_rdy, input logic e_stl, input logic e_hit, input logic e_we,
    input logic [4:0] e_a3, input logic [31:0] e_wd, input logic [31:0] e_pc);
    vec_t r;
    r.rst = rst; r.pwe = pwe; r.pa3 = pa3; r.pwd = pwd; r.ppc = ppc;
    r.mv = mv; r.ma3 = ma3; r.mwd = mwd; r.mpc = mpc; r.rda = rda;
    r.e_rdy = e_rdy; r.e_stl = e_stl; r.e_hit = e_hit; r.e_we = e_we;
    r.e_a3 = e_a3; r.e_wd = e_wd; r.e_pc = e_pc;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic pwe, input logic [4:0] pa3, input logic [31:0] pwd,
                       input logic [31:0] ppc, input logic mv, input logic [4:0] ma3, input logic [31:0] mwd,
                       input logic [31:0] mpc, input logic [4:0] rda);
    reset = rst; pipe_we = pwe; pipe_a3 = pa3; pipe_wd = pwd; pipe_pc = ppc;
    mdu_valid = mv; mdu_a3 = ma3; mdu_wd = mwd; mdu_pc = mpc; rd_a = rda;
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);

    // Each row: inputs for this cycle; expected comb outputs now and grf_* from the previous edge.
    //                  rst pwe pa3  pwd          ppc          mv ma3  mwd         mpc          rda   rdy stl hit we a3  wd           pc
    vecs.push_back(v(1, 0, 0,  0,           0,           0, 0,  0,          0,           0,    0, 0, 0, 0, 0,  0,           0));
    vecs.push_back(v(0, 1, 5,  32'h1234,    32'h3000,    0, 0,  0,          0,           0,    1, 0, 0, 0, 0,  0,           0));
    vecs.push_back(v(0, 0, 0,  0,           0,           1, 8,  32'hAA,     32'h4000,    8,    1, 0, 0, 1, 5,  32'h1234,    32'h3000));
    vecs.push_back(v(0, 0, 0,  0,           0,           0, 0,  0,          0,           8,    1, 0, 1, 0, 5,  32'h1234,    32'h3000));
    vecs.push_back(v(0, 0, 0,  0,           0,           0, 0,  0,          0,           8,    1, 0, 0, 1, 8,  32'hAA,      32'h4000));
    vecs.push_back(v(0, 1, 0,  32'hFFFF,    32'h3100,    1, 0,  32'hBB,     32'h4100,    0,    1, 0, 0, 0, 8,  32'hAA,      32'h4000));
    vecs.push_back(v(0, 0, 0,  0,           0,           0, 0,  0,          0,           0,    1, 0, 0, 0, 8,  32'hAA,      32'h4000));
    vecs.push_back(v(0, 0, 0,  0,           0,           1, 3,  32'h1,      32'h5000,    3,    1, 0, 0, 0, 8,  32'hAA,      32'h4000));
    vecs.push_back(v(0, 0, 0,  0,           0,           1, 3,  32'h2,      32'h5004,    3,    1, 0, 1, 0, 8,  32'hAA,      32'h4000));
    vecs.push_back(v(0, 0, 0,  0,           0,           0, 0,  0,          0,           3,    1, 0, 1, 1, 3,  32'h1,       32'h5000));
    vecs.push_back(v(0, 0, 0,  0,           0,           0, 0,  0,          0,           3,    1, 0, 0, 1, 3,  32'h2,       32'h5004));
    vecs.push_back(v(0, 0, 0,  0,           0,           0, 0,  0,          0,           3,    1, 0, 0, 0, 3,  32'h2,       32'h5004));
    vecs.push_back(v(0, 1, 1,  32'h11,      32'h100,     1, 9,  32'hC1,     32'h6000,    9,    1, 0, 0, 0, 3,  32'h2,       32'h5004));
    vecs.push_back(v(0, 1, 2,  32'h22,      32'h104,     1, 10, 32'hC2,     32'h6004,    9,    1, 0, 1, 1, 1,  32'h11,      32'h100));
    vecs.push_back(v(1, 1, 4,  32'h44,      32'h108,     1, 11, 32'hC3,     32'h6008,    9,    0, 0, 0, 1, 2,  32'h22,      32'h104));
    vecs.push_back(v(0, 0, 0,  0,           0,           0, 0,  0,          0,           9,    1, 0, 0, 0, 0,  0,           0));
    vecs.push_back(v(0, 0, 0,  0,           0,           0, 0,  0,          0,           10,   1, 0, 0, 0, 0,  0,           0));
    vecs.push_back(v(0, 0, 0,  0,           0,           0, 0,  0,          0,           11,   1, 0, 0, 0, 0,  0,           0));
    vecs.push_back(v(0, 0, 0,  0,           0,           0, 0,  0,          0,           0,    1, 0, 0, 0, 0,  0,           0));

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].pwe, vecs[i].pa3, vecs[i].pwd, vecs[i].ppc,
            vecs[i].mv, vecs[i].ma3, vecs[i].mwd, vecs[i].mpc, vecs[i].rda);
      #1;
      check($sformatf("r%0d_ready", i), 32'(mdu_ready), 32'(vecs[i].e_rdy));
      check($sformatf("r%0d_stall", i), 32'(stall),     32'(vecs[i].e_stl));
      check($sformatf("r%0d_hit", i),   32'(pend_hit),  32'(vecs[i].e_hit));
      check($sformatf("r%0d_we", i),    32'(grf_we),    32'(vecs[i].e_we));
      check($sformatf("r%0d_a3", i),    32'(grf_a3),    32'(vecs[i].e_a3));
      check($sformatf("r%0d_wd", i),    grf_wd,         vecs[i].e_wd);
      check($sformatf("r%0d_pc", i),    grf_pc,         vecs[i].e_pc);
    end

    // Pipe writes every cycle; two MDU pushes in cycles 0 and 1. The head ages 0..7 over
    // edges 0..7, so stall is high in cycle 8 and the head commits on that edge.
    // The second entry restarts at age 0 after the pop and forces stall in cycle 16.
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      drive(0, 1, 7, 32'h100 + 32'(c), 32'h8000 + 32'(4 * c),
            (c < 2), (c == 0) ? 5'd12 : 5'd13, (c == 0) ? 32'hD1 : 32'hD2, 32'h7000 + 32'(4 * c), 13);
      #1;
      check($sformatf("s%0d_stall", c), 32'(stall), 32'((c == 8) || (c == 16)));
      if (c < 2 || c == 9 || c == 17) check($sformatf("s%0d_ready", c), 32'(mdu_ready), 32'd1);
      if (c == 2 || c == 8)           check($sformatf("s%0d_ready", c), 32'(mdu_ready), 32'd0);
      if (c == 2 || c == 16)          check($sformatf("s%0d_hit", c), 32'(pend_hit), 32'd1);
      if (c == 8) begin
        check("s8_a3", 32'(grf_a3), 32'd7);
        check("s8_wd", grf_wd, 32'h107);
      end
      if (c == 9) begin
        check("s9_we", 32'(grf_we), 32'd1);
        check("s9_a3", 32'(grf_a3), 32'd12);
        check("s9_wd", grf_wd, 32'hD1);
        check("s9_pc", grf_pc, 32'h7000);
      end
      if (c == 10) check("s10_wd", grf_wd, 32'h109);
      if (c == 17) begin
        check("s17_we", 32'(grf_we), 32'd1);
        check("s17_a3", 32'(grf_a3), 32'd13);
        check("s17_wd", grf_wd, 32'hD2);
        check("s17_hit", 32'(pend_hit), 32'd0);
      end
    end

    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
